// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: sequences the shared ALU, unified memory and register file.
// Optional bne support is compiled in with `define MC_CTRL_BNE_EN.
module mc_ctrl_fsm #(
    parameter int unsigned RDY_TIMEOUT = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_en,
    output logic       o_iord,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_src,
    output logic       o_illegal,
    output logic       o_timeout
);

    localparam int unsigned CNT_W = 16;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;
`ifdef MC_CTRL_BNE_EN
    logic             is_bne_q, is_bne_d;
`endif

    // State, wait counter and branch-sense registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_FETCH;
            cnt_q    <= '0;
`ifdef MC_CTRL_BNE_EN
            is_bne_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`ifdef MC_CTRL_BNE_EN
            is_bne_q <= is_bne_d;
`endif
        end
    end

    // Next-state and Moore output decode, with ready/zero gating in FETCH and BRANCH
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        waiting      = 1'b0;
`ifdef MC_CTRL_BNE_EN
        is_bne_d     = is_bne_q;
`endif
        o_pc_en      = 1'b0;
        o_iord       = 1'b0;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_ir_write   = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_dst    = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 2'b00;
        o_pc_src     = 2'b00;
        o_illegal    = 1'b0;
        o_timeout    = 1'b0;

        case (state_q)
            S_FETCH: begin
                o_mem_rd    = 1'b1;
                o_alu_src_b = 2'b01;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_en    = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                o_alu_src_b = 2'b11;
`ifdef MC_CTRL_BNE_EN
                is_bne_d    = (i_opcode == OP_BNE);
`endif
                case (i_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        o_illegal = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                state_d     = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_mem_rd = 1'b1;
                o_iord   = 1'b1;
                if (i_mem_ready) state_d = S_MEMWB;
                else             waiting = 1'b1;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                o_mem_wr = 1'b1;
                o_iord   = 1'b1;
                if (i_mem_ready) state_d = S_FETCH;
                else             waiting = 1'b1;
            end
            S_EXECUTE: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = 2'b01;
                o_pc_src    = 2'b01;
`ifdef MC_CTRL_BNE_EN
                o_pc_en     = is_bne_q ? !i_zero : i_zero;
`else
                o_pc_en     = i_zero;
`endif
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                o_reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                o_pc_src = 2'b10;
                o_pc_en  = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Abort a stalled memory state; a same-cycle ready never reaches here
        if (waiting && (RDY_TIMEOUT != 0)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(RDY_TIMEOUT)) begin
                o_timeout = 1'b1;
                o_mem_wr  = 1'b0;
                state_d   = S_FETCH;
                cnt_d     = '0;
            end
        end

        if (i_rst) begin
            o_pc_en     = 1'b0;
            o_ir_write  = 1'b0;
            o_reg_write = 1'b0;
            o_mem_wr    = 1'b0;
            o_mem_rd    = 1'b0;
            o_illegal   = 1'b0;
            o_timeout   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm, built with RDY_TIMEOUT=4.
module tb_mc_ctrl_fsm;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [5:0] i_opcode = 6'b0;
    logic       i_zero = 1'b0;
    logic       i_mem_ready = 1'b0;
    logic       o_pc_en, o_iord, o_mem_rd, o_mem_wr, o_ir_write, o_mem_to_reg;
    logic       o_reg_dst, o_reg_write, o_alu_src_a, o_illegal, o_timeout;
    logic [1:0] o_alu_src_b, o_alu_op, o_pc_src;

    int n_vec = 0;
    int n_err = 0;

    mc_ctrl_fsm #(.RDY_TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_zero(i_zero),
        .i_mem_ready(i_mem_ready), .o_pc_en(o_pc_en), .o_iord(o_iord),
        .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_ir_write(o_ir_write),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_dst(o_reg_dst), .o_reg_write(o_reg_write),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_op(o_alu_op),
        .o_pc_src(o_pc_src), .o_illegal(o_illegal), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // {pc_en,iord,mem_rd,mem_wr,ir_write,mem_to_reg,reg_dst,reg_write,src_a,src_b,alu_op,pc_src,illegal,timeout}
    localparam logic [16:0] FR    = 17'b1_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [16:0] FW    = 17'b0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [16:0] FTO   = 17'b0_0_1_0_0_0_0_0_0_01_00_00_0_1;
    localparam logic [16:0] RSTF  = 17'b0_0_0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [16:0] DEC   = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [16:0] DECI  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [16:0] MADR  = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [16:0] MRD   = 17'b0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] MRDTO = 17'b0_1_1_0_0_0_0_0_0_00_00_00_0_1;
    localparam logic [16:0] MWB   = 17'b0_0_0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [16:0] MWR   = 17'b0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] EXE   = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [16:0] AWB   = 17'b0_0_0_0_0_0_1_1_0_00_00_00_0_0;
    localparam logic [16:0] AWBR  = 17'b0_0_0_0_0_0_1_0_0_00_00_00_0_0;
    localparam logic [16:0] BR1   = 17'b1_0_0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [16:0] BR0   = 17'b0_0_0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [16:0] IWB   = 17'b0_0_0_0_0_0_0_1_0_00_00_00_0_0;
    localparam logic [16:0] JMP   = 17'b1_0_0_0_0_0_0_0_0_00_00_10_0_0;

    function automatic logic [16:0] obs();
        return {o_pc_en, o_iord, o_mem_rd, o_mem_wr, o_ir_write, o_mem_to_reg, o_reg_dst,
                o_reg_write, o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_src, o_illegal, o_timeout};
    endfunction

    task automatic test_reset();
        logic [16:0] got;
        i_rst = 1'b1; i_mem_ready = 1'b1;
        repeat (2) begin
            #1; got = obs(); n_vec++;
            if (got !== RSTF) begin
                n_err++; $display("FAIL reset_forced: got %b want %b", got, RSTF);
            end
            @(posedge i_clk); #1;
        end
        i_rst = 1'b0; i_mem_ready = 1'b0;
        #1; got = obs(); n_vec++;
        if (got !== FW) begin
            n_err++; $display("FAIL reset_fetch: got %b want %b", got, FW);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_lw();
        logic [16:0] exp [6];
        logic        rdy [6];
        logic [16:0] got;
        exp = '{FR, DEC, MADR, MRD, MWB, FW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        i_opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            i_mem_ready = rdy[i]; #1; got = obs(); n_vec++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL lw cyc%0d: got %b want %b", i + 1, got, exp[i]);
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_sw();
        logic [16:0] exp [8];
        logic        rdy [8];
        logic [16:0] got;
        exp = '{FR, DEC, MADR, MWR, MWR, MWR, MWR, FW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        i_opcode = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            i_mem_ready = rdy[i]; #1; got = obs(); n_vec++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL sw cyc%0d: got %b want %b", i + 1, got, exp[i]);
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [16:0] exp [8];
        logic        rdy [8];
        logic        zr  [8];
        logic [16:0] got;
        exp = '{FR, DEC, BR1, FW, FR, DEC, BR0, FW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        zr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        i_opcode = 6'b000100;
        for (int i = 0; i < 8; i++) begin
            i_mem_ready = rdy[i]; i_zero = zr[i]; #1; got = obs(); n_vec++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL beq cyc%0d: got %b want %b", i, got, exp[i]);
            end
            @(posedge i_clk); #1;
        end
        i_zero = 1'b0;
    endtask

    task automatic test_alu();
        logic [16:0] exp [10];
        logic        rdy [10];
        logic [5:0]  op  [10];
        logic [16:0] got;
        exp = '{FR, DEC, EXE, AWB, FW, FR, DEC, MADR, IWB, FW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        op  = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000};
        for (int i = 0; i < 10; i++) begin
            i_mem_ready = rdy[i]; i_opcode = op[i]; #1; got = obs(); n_vec++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL rtype_addi cyc%0d: got %b want %b", i, got, exp[i]);
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_jump_illegal();
        logic [16:0] exp [12];
        logic        rdy [12];
        logic [5:0]  op  [12];
        logic [16:0] got;
        // bne opcode 000101 is illegal unless the optional feature is built in (zero=0 -> taken)
`ifdef MC_CTRL_BNE_EN
        exp = '{FR, DEC, JMP, FW, FR, DECI, FW, FW, FR, DEC, BR1, FW};
`else
        exp = '{FR, DEC, JMP, FW, FR, DECI, FW, FW, FR, DECI, FW, FW};
`endif
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        op  = '{6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b111111, 6'b111111,
                6'b111111, 6'b111111, 6'b000101, 6'b000101, 6'b000101, 6'b000101};
        i_zero = 1'b0;
        for (int i = 0; i < 12; i++) begin
            i_mem_ready = rdy[i]; i_opcode = op[i]; #1; got = obs(); n_vec++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL jump_illegal cyc%0d: got %b want %b", i, got, exp[i]);
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_rst_mid();
        logic [16:0] exp [10];
        logic        rdy [10];
        logic        rst [10];
        logic [16:0] got;
        exp = '{FR, DEC, EXE, RSTF, FW, FR, DEC, EXE, AWBR, FW};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rst = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        i_opcode = 6'b000000;
        for (int i = 0; i < 10; i++) begin
            i_mem_ready = rdy[i]; i_rst = rst[i]; #1; got = obs(); n_vec++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL rst_mid cyc%0d: got %b want %b", i, got, exp[i]);
            end
            @(posedge i_clk); #1;
        end
        i_rst = 1'b0;
    endtask

    task automatic test_timeout();
        logic [16:0] exp [20];
        logic        rdy [20];
        logic [5:0]  op  [20];
        logic [16:0] got;
        exp = '{FW, FW, FW, FTO, FW, FW, FW, FR, DEC, JMP,
                FR, DEC, MADR, MRD, MRD, MRD, MRDTO, FW, FR, DEC};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op  = '{6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b000010,
                6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b000010,
                6'b100011, 6'b100011, 6'b100011, 6'b100011, 6'b100011,
                6'b100011, 6'b100011, 6'b100011, 6'b000010, 6'b000010};
        i_rst = 1'b1; @(posedge i_clk); #1; i_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            i_mem_ready = rdy[i]; i_opcode = op[i]; #1; got = obs(); n_vec++;
            if (got !== exp[i]) begin
                n_err++; $display("FAIL timeout cyc%0d: got %b want %b", i, got, exp[i]);
            end
            @(posedge i_clk); #1;
        end
        // finish the trailing jump so the FSM rests in FETCH
        i_mem_ready = 1'b0; #1; got = obs(); n_vec++;
        if (got !== JMP) begin
            n_err++; $display("FAIL timeout_tail: got %b want %b", got, JMP);
        end
        @(posedge i_clk); #1;
    endtask

    initial begin
        @(posedge i_clk); #1;
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_alu();
        test_jump_illegal();
        test_rst_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
